// File: rtl/wb_arb_if.sv
// Writeback arbiter bus: pipeline write request, long-latency result handshake,
// registered regfile write port and decode-stage pending-read lookups.
// Master drives requests and read addresses; slave (the arbiter) drives the rest.
interface wb_arb_if;
  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_waddr;
  logic [31:0] lsu_wdata;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        pend1;
  logic        pend2;
  logic        stallreq;

  modport master (
    output mem_we, mem_waddr, mem_wdata,
    output lsu_valid, lsu_waddr, lsu_wdata,
    output raddr1, raddr2,
    input  lsu_ready, we, waddr, wdata, pend1, pend2, stallreq
  );

  modport slave (
    input  mem_we, mem_waddr, mem_wdata,
    input  lsu_valid, lsu_waddr, lsu_wdata,
    input  raddr1, raddr2,
    output lsu_ready, we, waddr, wdata, pend1, pend2, stallreq
  );
endinterface

// File: rtl/wb_arb.sv
// Regfile writeback arbiter: pipeline writes win, long-latency results queue in a small FIFO.
// Latency: pipeline write 1 cycle; lsu result at least 2 cycles (always through one buffer entry).
// Backpressure: lsu_ready drops and stallreq rises when the buffer is full; nothing is lost.
module wb_arb #(
  parameter int DEPTH = 2
) (
  input logic     clk,
  input logic     rst,
  wb_arb_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Buffer state: an entry is "live" when it still owes a regfile write.
  // Killed entries keep their slot (and count) until they reach the head.
  logic [DEPTH-1:0] r_live;
  logic [4:0]       r_ent_addr [DEPTH];
  logic [31:0]      r_ent_data [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_cnt;

  logic             r_we;
  logic [4:0]       r_waddr;
  logic [31:0]      r_wdata;

  logic w_ready;
  logic w_take;
  logic w_push;
  logic w_pop;
  logic w_push_live;
  logic w_head_live;
  logic w_pend1;
  logic w_pend2;

  assign w_ready     = (r_cnt < FULL) && !rst;
  assign w_take      = bus.mem_we && (bus.mem_waddr != 5'd0);
  // r0 results are acknowledged but dropped: they would never be written anyway.
  assign w_push      = bus.lsu_valid && w_ready && (bus.lsu_waddr != 5'd0);
  assign w_pop       = !w_take && (r_cnt != '0);
  // A same-cycle pipeline write to the same register is the newer value.
  assign w_push_live = !(w_take && (bus.lsu_waddr == bus.mem_waddr));
  assign w_head_live = r_live[r_rd_ptr];

  // Buffer control: kill superseded entries, pop head, push new result, track occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_live   <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_take && r_live[i] && (r_ent_addr[i] == bus.mem_waddr)) begin
          r_live[i] <= 1'b0;
        end
      end
      if (w_pop) begin
        r_live[r_rd_ptr] <= 1'b0;
        r_rd_ptr         <= r_rd_ptr + PW'(1);
      end
      if (w_push) begin
        r_live[r_wr_ptr] <= w_push_live;
        r_wr_ptr         <= r_wr_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Buffer payload: captured on push, validity is tracked separately by r_live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ent_addr[r_wr_ptr] <= bus.lsu_waddr;
      r_ent_data[r_wr_ptr] <= bus.lsu_wdata;
    end
  end

  // Regfile write port: pipeline first, then buffer head; a killed head pops silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_waddr <= 5'd0;
      r_wdata <= 32'd0;
    end else if (w_take) begin
      r_we    <= 1'b1;
      r_waddr <= bus.mem_waddr;
      r_wdata <= bus.mem_wdata;
    end else if (w_pop) begin
      r_we <= w_head_live;
      if (w_head_live) begin
        r_waddr <= r_ent_addr[r_rd_ptr];
        r_wdata <= r_ent_data[r_rd_ptr];
      end
    end else begin
      r_we <= 1'b0;
    end
  end

  // Pending-read lookup: decode must wait for any live buffered write to its source.
  always_comb begin
    w_pend1 = 1'b0;
    w_pend2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_live[i] && (r_ent_addr[i] == bus.raddr1)) w_pend1 = 1'b1;
      if (r_live[i] && (r_ent_addr[i] == bus.raddr2)) w_pend2 = 1'b1;
    end
    if (rst || (bus.raddr1 == 5'd0)) w_pend1 = 1'b0;
    if (rst || (bus.raddr2 == 5'd0)) w_pend2 = 1'b0;
  end

  assign bus.lsu_ready = w_ready;
  assign bus.stallreq  = (r_cnt == FULL) && !rst;
  assign bus.pend1     = w_pend1;
  assign bus.pend2     = w_pend2;
  assign bus.we        = r_we;
  assign bus.waddr     = r_waddr;
  assign bus.wdata     = r_wdata;

endmodule

// File: tb/tb_wb_arb.sv
// Bench for wb_arb: directed scenarios then random traffic against a queue-based model.
// Inputs change 1 time unit after a rising edge; outputs are sampled mid-cycle.
module tb_wb_arb;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  wb_arb_if ifc ();

  wb_arb #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  // Reference model: buffered results as a FIFO queue of {addr, data, live}.
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    bit          live;
  } ent_t;

  ent_t        q[$];
  logic        e_we;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit pend_of(input logic [4:0] ra);
    bit p = 1'b0;
    if (rst || ra == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i].live && q[i].a == ra) p = 1'b1;
    return p;
  endfunction

  task automatic drive(input bit mw, input int ma, input int md,
                       input bit lv, input int la, input int ld,
                       input int r1, input int r2);
    ifc.mem_we    = mw;
    ifc.mem_waddr = 5'(ma);
    ifc.mem_wdata = 32'(md);
    ifc.lsu_valid = lv;
    ifc.lsu_waddr = 5'(la);
    ifc.lsu_wdata = 32'(ld);
    ifc.raddr1    = 5'(r1);
    ifc.raddr2    = 5'(r2);
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic do_cycle();
    bit   rdy, take, acc;
    ent_t h, n;
    #2;
    rdy = !rst && (q.size() < DEPTH);
    chk("lsu_ready", ifc.lsu_ready, rdy);
    chk("stallreq", ifc.stallreq, !rst && (q.size() == DEPTH));
    chk("pend1", ifc.pend1, pend_of(ifc.raddr1));
    chk("pend2", ifc.pend2, pend_of(ifc.raddr2));
    if (rst) begin
      q.delete();
      e_we = 1'b0; e_waddr = '0; e_wdata = '0;
    end else begin
      take = ifc.mem_we && ifc.mem_waddr != 5'd0;
      acc  = ifc.lsu_valid && rdy;
      if (take) begin
        e_we = 1'b1; e_waddr = ifc.mem_waddr; e_wdata = ifc.mem_wdata;
        foreach (q[i]) if (q[i].a == ifc.mem_waddr) q[i].live = 1'b0;
      end else if (q.size() > 0) begin
        h = q.pop_front();
        e_we = h.live;
        if (h.live) begin e_waddr = h.a; e_wdata = h.d; end
      end else begin
        e_we = 1'b0;
      end
      if (acc && ifc.lsu_waddr != 5'd0) begin
        n.a = ifc.lsu_waddr;
        n.d = ifc.lsu_wdata;
        n.live = !(take && ifc.mem_waddr == ifc.lsu_waddr);
        q.push_back(n);
      end
    end
    @(posedge clk);
    #1;
    chk("we", ifc.we, e_we);
    chk("waddr", ifc.waddr, e_waddr);
    chk("wdata", ifc.wdata, e_wdata);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      do_cycle();
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    do_cycle();
    do_cycle();
    chk("reset_we", ifc.we, 0);
    rst = 1'b0;
    idle(1);

    // Pipeline write lands one cycle later.
    drive(1, 5, 32'h11, 0, 0, 0, 0, 0);
    do_cycle();
    chk("pipe_we", ifc.we, 1);
    chk("pipe_waddr", ifc.waddr, 5);
    chk("pipe_wdata", ifc.wdata, 32'h11);
    idle(1);

    // Long-latency result: pending one cycle, written two cycles after accept.
    drive(0, 0, 0, 1, 7, 32'hAA, 0, 0);
    do_cycle();
    drive(0, 0, 0, 0, 0, 0, 7, 7);
    do_cycle();
    chk("lsu_lat_we", ifc.we, 1);
    chk("lsu_lat_waddr", ifc.waddr, 7);
    chk("lsu_lat_wdata", ifc.wdata, 32'hAA);
    idle(2);

    // Fill with pipeline writes holding the port; third offer refused.
    drive(1, 1, 32'h100, 1, 3, 32'h33, 3, 4);
    do_cycle();
    drive(1, 1, 32'h101, 1, 4, 32'h44, 3, 4);
    do_cycle();
    drive(1, 1, 32'h102, 1, 6, 32'h66, 6, 4);
    do_cycle();
    chk("full_stall", ifc.stallreq, 1);
    idle(4);

    // Buffered r9 superseded by a pipeline write; killed head pops silently.
    drive(0, 0, 0, 1, 9, 32'h1, 9, 0);
    do_cycle();
    drive(1, 9, 32'h2, 0, 0, 0, 9, 0);
    do_cycle();
    chk("kill_wdata", ifc.wdata, 32'h2);
    idle(3);

    // Same-cycle lsu accept and pipeline write to one register.
    drive(1, 12, 32'h5, 1, 12, 32'h6, 12, 0);
    do_cycle();
    idle(3);

    // r0 result accepted but never written.
    drive(0, 0, 0, 1, 0, 32'hDEAD, 0, 0);
    do_cycle();
    idle(3);

    // mem_we to r0 does not block the buffer.
    drive(0, 0, 0, 1, 8, 32'h88, 8, 0);
    do_cycle();
    drive(1, 0, 32'h77, 0, 0, 0, 8, 0);
    do_cycle();
    chk("r0_noblock_waddr", ifc.waddr, 8);
    idle(2);

    // Reset with an entry buffered: discarded, no write after release.
    drive(0, 0, 0, 1, 10, 32'hA0, 10, 0);
    do_cycle();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 10, 0);
    do_cycle();
    chk("rst_mid_we", ifc.we, 0);
    rst = 1'b0;
    idle(4);

    // Random traffic over a narrow address range to force collisions and wraps.
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(99) < 2);
      drive($urandom_range(99) < 40, $urandom_range(7), $urandom,
            $urandom_range(99) < 60, $urandom_range(7), $urandom,
            $urandom_range(7), $urandom_range(7));
      do_cycle();
    end
    rst = 1'b0;
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/wb_arb.md
WB_ARB -- requirements
Module: wb_arb

Interface
REQ-001 SHALL have parameter: DEPTH, 2, long-latency result buffer entries (legal values 2 or 4).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: mem_we  input  1  pipeline (MEM/WB) register write request.
REQ-005 SHALL have port: mem_waddr  input  5  pipeline destination register.
REQ-006 SHALL have port: mem_wdata  input  32  pipeline write data.
REQ-007 SHALL have port: lsu_valid  input  1  long-latency result offered.
REQ-008 SHALL have port: lsu_ready  output  1  buffer can accept; equals (count<DEPTH) && !rst, combinational.
REQ-009 SHALL have port: lsu_waddr  input  5  long-latency destination register.
REQ-010 SHALL have port: lsu_wdata  input  32  long-latency result data.
REQ-011 SHALL have port: we  output  1  registered regfile write enable.
REQ-012 SHALL have port: waddr  output  5  registered regfile write address.
REQ-013 SHALL have port: wdata  output  32  registered regfile write data.
REQ-014 SHALL have port: raddr1, raddr2  input  5 each  decode-stage read addresses.
REQ-015 SHALL have port: pend1, pend2  output  1 each  combinational: raddrN nonzero and matches waddr of a live buffer entry.
REQ-016 SHALL have port: stallreq  output  1  combinational: count==DEPTH.

Function
REQ-017 SHALL accept an lsu result in cycle T iff lsu_valid && lsu_ready; entry visible at buffer head from T+1.
REQ-018 SHALL, at each rising edge, load we/waddr/wdata from the pipeline request if mem_we && mem_waddr!=0 (latency 1).
REQ-019 SHALL otherwise pop the buffer head and, if live, load it into we/waddr/wdata; a killed head is popped with we=0.
REQ-020 SHALL otherwise drive we=0 and hold waddr/wdata.
REQ-021 SHALL give minimum lsu-to-write latency of 2 cycles (accept T, we=1 in T+2) when no pipeline write in T+1.
REQ-022 SHALL never bypass the buffer; lsu data always passes through one buffer entry.
REQ-023 SHALL accept but not enqueue lsu results with lsu_waddr==0; mem_we with mem_waddr==0 SHALL not block the buffer.
REQ-024 SHALL, when a pipeline write to address A is taken, kill every live buffer entry with waddr==A (newer pipeline value wins).
REQ-025 SHALL, when an lsu result to A is accepted in the same cycle as a taken pipeline write to A, enqueue it killed.
REQ-026 SHALL support simultaneous push and pop: count unchanged, FIFO order preserved, pointers wrap modulo DEPTH.
REQ-027 SHALL ignore lsu_valid while lsu_ready=0; no entry lost or duplicated at full.
REQ-028 SHALL keep FIFO order among lsu results; pipeline writes always have priority over buffer pops.
REQ-029 SHALL assert stallreq while full; if mem_we arrives while full, the pipeline write still wins and the buffer holds.
REQ-030 SHALL exclude killed entries from pend1/pend2.

Reset
REQ-031 SHALL, with rst=1 at an edge, set count=0, read/write pointers=0, all entries invalid, we=0, waddr=0, wdata=0.
REQ-032 SHALL, during reset, drive lsu_ready=0, stallreq=0, pend1=pend2=0.
REQ-033 SHALL discard buffered entries on reset mid-operation; no write issued for them after reset release.

Verification
REQ-034 SHALL cover: mem_we=1, waddr=5, wdata=0x11 in cycle 0 -> we=1, waddr=5, wdata=0x11 in cycle 1.
REQ-035 SHALL cover: lsu accept (r7, 0xAA) cycle 0, no mem_we -> we=1, waddr=7, wdata=0xAA in cycle 2; pend1=1 for raddr1=7 in cycle 1.
REQ-036 SHALL cover: DEPTH=2, two lsu accepts back-to-back with mem_we held high to r1 -> lsu_ready=0, stallreq=1 in cycle 2; third lsu_valid not accepted.
REQ-037 SHALL cover: lsu (r9, 0x1) buffered, then pipeline write r9=0x2 -> regfile sees only r9=0x2; killed pop yields we=0.
REQ-038 SHALL cover: lsu to r0 accepted -> no enqueue, count stays 0, we never asserted for r0.
REQ-039 SHALL cover: one entry buffered, rst=1 one cycle -> we=0, count=0 next cycle; no write after release.
